// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: datapath width, next-PC select
// encodings and the bubble instruction.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_RSV = 2'b11
    } pcSrc_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Only branch and jump redirect the front end; the reserved code acts sequential.
    function automatic logic isRedirect(input logic [1:0] src);
        return (src == PCSRC_BR) || (src == PCSRC_JMP);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with load enable and a squash input that overrides it.
// The squash value doubles as the reset value so a flushed stage looks freshly reset.
module ifid_reg #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= FLUSH_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, IF/ID register
// and debug counters for stall and redirect events.
module if_stage #(
    parameter int               XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IFIDWrite,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [XLEN-1:0] ifid_instr,
    output logic            ifid_valid,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);

    import cpu_pkg::*;

    localparam int IFID_W = 2 * XLEN + 1;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {XLEN'(NOP_INSTR), {XLEN{1'b0}}, 1'b0};

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] redirectTarget;
    logic [XLEN-1:0] nextPc;
    logic            redirect;
    logic            stallEvent;

    assign imem_addr = pc;
    assign pcPlus4   = pc + XLEN'(4);
    assign redirect  = isRedirect(pc_src);
    assign stallEvent = !PCWrite && !redirect;

    // Redirect targets are word-aligned by dropping the low two bits.
    always_comb begin
        redirectTarget = (pc_src == PCSRC_JMP) ? jump_target : branch_target;
        redirectTarget[1:0] = 2'b00;
        if (redirect) begin
            nextPc = redirectTarget;
        end else if (PCWrite) begin
            nextPc = pcPlus4;
        end else begin
            nextPc = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= nextPc;
        end
    end

    // Counters stick at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stallEvent && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    ifid_reg #(
        .WIDTH       (IFID_W),
        .FLUSH_VALUE (IFID_BUBBLE)
    ) ifidRegInst (
        .clk    (clk),
        .reset  (reset),
        .enable (IFIDWrite),
        .flush  (redirect),
        .d      ({imem_rdata, pcPlus4, 1'b1}),
        .q      ({ifid_instr, ifid_pc4, ifid_valid})
    );

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: a word-level reference model tracks the fetch
// stage and every cycle's outputs are compared against it, after a directed walk.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        IFIDWrite;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    logic [31:0] mPc, mInstr, mPc4, mStall, mFlush;
    logic        mValid;

    always #5 clk = ~clk;

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    // Synthetic instruction memory: a distinct, address-dependent word everywhere.
    function automatic logic [31:0] instrAt(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = instrAt(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced once per rising edge from the inputs held across it.
    task automatic modelStep();
        logic        redir;
        logic [31:0] tgt;
        if (reset) begin
            mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
            mStall = 32'h0; mFlush = 32'h0;
            return;
        end
        redir = (pc_src == 2'd1) || (pc_src == 2'd2);
        tgt   = (pc_src == 2'd2) ? jump_target : branch_target;
        tgt   = (tgt / 4) * 4;
        if (redir) begin
            mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
        end else if (IFIDWrite) begin
            mInstr = instrAt(mPc); mPc4 = mPc + 32'd4; mValid = 1'b1;
        end
        if (!PCWrite && !redir && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
        if (redir && mFlush != 32'hFFFF_FFFF) mFlush = mFlush + 1;
        if (redir) mPc = tgt;
        else if (PCWrite) mPc = mPc + 32'd4;
    endtask

    task automatic applyStimulus(input logic rst, input logic pcw, input logic ifw,
                                 input logic [1:0] src, input logic [31:0] bt,
                                 input logic [31:0] jt);
        reset = rst; PCWrite = pcw; IFIDWrite = ifw; pc_src = src;
        branch_target = bt; jump_target = jt;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("imem_addr",   imem_addr,   mPc);
            checkOutput("ifid_instr",  ifid_instr,  mInstr);
            checkOutput("ifid_pc4",    ifid_pc4,    mPc4);
            checkOutput("ifid_valid",  {31'b0, ifid_valid}, {31'b0, mValid});
            checkOutput("stall_count", stall_count, mStall);
            checkOutput("flush_count", flush_count, mFlush);
        end
    end

    initial begin
        logic pcw, ifw;
        logic [1:0] src;
        int r;

        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        checkEn = 1'b1;
        checkOutput("reset_pc", imem_addr, 32'h0);
        checkOutput("reset_valid", {31'b0, ifid_valid}, 32'h0);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        checkOutput("seq_pc_4", imem_addr, 32'h4);
        checkOutput("seq_pc4_4", ifid_pc4, 32'h4);
        checkOutput("seq_valid", {31'b0, ifid_valid}, 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        checkOutput("seq_pc_8", imem_addr, 32'h8);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        checkOutput("stall_pc", imem_addr, 32'h8);
        checkOutput("stall_ifid_pc4", ifid_pc4, 32'h8);
        checkOutput("stall_ifid_instr", ifid_instr, instrAt(32'h4));
        checkOutput("stall_count_2", stall_count, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        checkOutput("resume_pc", imem_addr, 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        checkOutput("seq_pc_10", imem_addr, 32'h10);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 32'h40, 32'h0);
        checkOutput("branch_pc", imem_addr, 32'h40);
        checkOutput("branch_bubble", {31'b0, ifid_valid}, 32'h0);
        checkOutput("flush_count_1", flush_count, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0);
        checkOutput("branch_target_instr", ifid_instr, instrAt(32'h40));
        checkOutput("branch_target_pc4", ifid_pc4, 32'h44);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h103);
        checkOutput("jump_stall_pc", imem_addr, 32'h100);
        checkOutput("jump_stall_valid", {31'b0, ifid_valid}, 32'h0);
        checkOutput("jump_stall_scount", stall_count, 32'd2);
        checkOutput("jump_stall_fcount", flush_count, 32'd2);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFF);
        checkOutput("wrap_setup_pc", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 32'h80, 32'h90);
        checkOutput("wrap_pc", imem_addr, 32'h0);
        checkOutput("wrap_ifid_pc4", ifid_pc4, 32'h0);
        checkOutput("wrap_valid", {31'b0, ifid_valid}, 32'h1);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 32'h200, 32'h0);
        checkOutput("rst_stall_pc", imem_addr, 32'h0);
        checkOutput("rst_stall_valid", {31'b0, ifid_valid}, 32'h0);
        checkOutput("rst_stall_scount", stall_count, 32'h0);
        checkOutput("rst_stall_fcount", flush_count, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 99);
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : pcw;
            src = (r < 70) ? 2'd0 : 2'($urandom_range(1, 3));
            applyStimulus(($urandom_range(0, 63) == 0), pcw, ifw, src, $urandom, $urandom);
        end

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipelined CPU: holds the program counter, selects the next PC, and drives the IF/ID pipeline register that feeds decode. It consumes the hazard unit's `PCWrite` and `IFIDWrite` stall controls and the branch/jump redirect from later stages. It also counts stall and flush events for debug.

## Interface
Parameters:
- `XLEN`, 32, datapath and address width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `PCWrite`  in  1  1 = PC may advance; 0 = hold PC (load-use stall)
- `IFIDWrite`  in  1  1 = IF/ID may load; 0 = hold IF/ID
- `pc_src`  in  2  next-PC select: 00 = sequential, 01 = branch, 10 = jump, 11 = reserved (treated as 00)
- `branch_target`  in  XLEN  taken-branch target
- `jump_target`  in  XLEN  jump target
- `imem_addr`  out  XLEN  instruction-memory address; equals current PC (combinational)
- `imem_rdata`  in  XLEN  instruction word at `imem_addr`, combinational read
- `ifid_pc4`  out  XLEN  registered PC+4 of the instruction in ID
- `ifid_instr`  out  XLEN  registered instruction in ID
- `ifid_valid`  out  1  1 = `ifid_instr` is a real instruction; 0 = bubble
- `stall_count`  out  32  cycles with stall asserted and no redirect (saturating)
- `flush_count`  out  32  redirect events (saturating)

Clock is `clk`. Reset is `reset`, synchronous and active-high. There is only one clock.

## Operation
- Redirect condition: `pc_src` is 01 or 10.
- Next PC priority, evaluated each cycle:
  - Redirect: PC loads the selected target with bits [1:0] forced to 0. This applies regardless of `PCWrite`.
  - Else if `PCWrite`=1: PC loads PC+4.
  - Else: PC holds.
- IF/ID register, evaluated each cycle:
  - Redirect: load the NOP bubble (`ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0). This applies regardless of `IFIDWrite`.
  - Else if `IFIDWrite`=1: load `imem_rdata`, PC+4, and `ifid_valid`=1.
  - Else: hold all three fields.
- Redirect wins over stall. The stalled instruction in ID is on the wrong path and is squashed.
- PC+4 wraps modulo 2^XLEN: PC 32'hFFFF_FFFC advances to 0.
- `PCWrite` and `IFIDWrite` are normally driven together. If they disagree, each register follows its own enable independently. No error is flagged.
- Counters:
  - `stall_count` increments when `PCWrite`=0 and there is no redirect.
  - `flush_count` increments on each redirect cycle.
  - Both saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- All state updates on the rising edge of `clk`.
- `imem_addr` follows PC combinationally, with zero-cycle latency.
- An instruction fetched at PC in cycle N appears on `ifid_*` in cycle N+1.
- Redirect asserted in cycle N:
  - PC = target in cycle N+1.
  - `ifid_valid`=0 in cycle N+1.
  - The target instruction appears in IF/ID in cycle N+2 (one-bubble penalty).
- Stall lasting K cycles: PC and IF/ID are frozen for K cycles and resume on the first cycle with `PCWrite`=1.
- Reset values, applied one edge after `reset`=1:
  - PC = `RESET_PC`
  - `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0
  - both counters = 0
- Reset overrides redirect and stall in the same cycle.
- Reset mid-stall or mid-redirect discards the in-flight state. The first valid fetch after reset is at `RESET_PC`.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN`
  - `pc_src` encodings: `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_JMP`
  - `NOP_INSTR` = 32'h0000_0000
- Sub-module `ifid_reg`: the IF/ID pipeline register with `enable` and `flush` inputs.
  - `flush` has priority over `enable`.
  - It is reusable for the later pipeline registers.
- The PC register, next-PC mux and counters live in `if_stage`.

## Test plan
- Reset, then 4 cycles with `PCWrite`=`IFIDWrite`=1 and `pc_src`=00 -> `imem_addr` is 0, 4, 8, C. `ifid_pc4` lags one cycle: 4, 8, C. `ifid_valid`=1 from the second cycle.
- Stall: `PCWrite`=`IFIDWrite`=0 for 2 cycles at PC=8 -> PC held at 8 and IF/ID held at the PC=4 instruction for 2 cycles. `stall_count`=2. Fetch resumes at C.
- Branch: `pc_src`=01 with `branch_target`=32'h40 at PC=10 -> next PC=40 and `ifid_valid`=0. The instruction from 40 is in IF/ID one cycle later. `flush_count`=1.
- Redirect and stall together: `pc_src`=10, `jump_target`=32'h103, `PCWrite`=0 -> PC=100 (low bits cleared), IF/ID flushed. `stall_count` unchanged, `flush_count` +1.
- Wrap: PC=32'hFFFF_FFFC, sequential step -> PC=0.
- Assert `reset` during a stall with IF/ID valid -> PC=`RESET_PC`, `ifid_valid`=0, both counters 0 on the next cycle.
